// File: rtl/jk_register.sv
// jk_register: a bank of WIDTH independent JK-style state bits with
// alternative load, toggle and rotate modes, plus change tracking.
//
// Ports:
//   Clk      - sole clock, all state updates on the rising edge
//   Rst_n    - synchronous active-low reset (clears Q, Changed, ChgCnt)
//   En       - update enable; 0 freezes Q and forces Changed to 0
//   Mode     - 00 JK, 01 parallel load of D, 10 toggle where J=1, 11 rotate left
//   J, K     - per-bit set / reset inputs
//   D        - parallel load data (Mode 01)
//   Clr      - synchronous clear of ChgCnt only, wins over an increment
//   Q        - registered state
//   Qbar     - combinational inverse of Q
//   Changed  - registered mask of bits that flipped at the last edge
//   ChgCnt   - saturating count of edges at which Q changed
module jk_register #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             En,
  input  logic [1:0]       Mode,
  input  logic [WIDTH-1:0] J,
  input  logic [WIDTH-1:0] K,
  input  logic [WIDTH-1:0] D,
  input  logic             Clr,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qbar,
  output logic [WIDTH-1:0] Changed,
  output logic [CNT_W-1:0] ChgCnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [WIDTH-1:0] Q_ZERO = {WIDTH{1'b0}};

  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] changed_r;
  logic [CNT_W-1:0] cnt_r;

  logic [WIDTH-1:0] q_next_s;
  logic [WIDTH-1:0] rot_s;
  logic [WIDTH-1:0] changed_next_s;
  logic [CNT_W-1:0] cnt_next_s;

  // Rotate left by one; the modulo index makes WIDTH=1 degenerate to a hold.
  always_comb begin
    rot_s = q_r;
    for (int i = 0; i < WIDTH; i++) begin
      rot_s[i] = q_r[(i + WIDTH - 1) % WIDTH];
    end
  end

  // Next-state selection for Q; holding is the default when disabled.
  always_comb begin
    q_next_s = q_r;
    if (En) begin
      case (Mode)
        2'b00:   q_next_s = (J & ~q_r) | (~K & q_r);  // JK characteristic equation
        2'b01:   q_next_s = D;
        2'b10:   q_next_s = q_r ^ J;
        2'b11:   q_next_s = rot_s;
        default: q_next_s = q_r;
      endcase
    end else begin
      q_next_s = q_r;
    end
  end

  // Change mask and saturating change counter; Clr overrides any increment.
  always_comb begin
    changed_next_s = q_next_s ^ q_r;
    cnt_next_s     = cnt_r;
    if (Clr) begin
      cnt_next_s = CNT_ZERO;
    end else if ((changed_next_s != Q_ZERO) && (cnt_r != CNT_MAX)) begin
      cnt_next_s = cnt_r + CNT_ONE;
    end else begin
      cnt_next_s = cnt_r;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      q_r       <= Q_ZERO;
      changed_r <= Q_ZERO;
      cnt_r     <= CNT_ZERO;
    end else begin
      q_r       <= q_next_s;
      changed_r <= changed_next_s;
      cnt_r     <= cnt_next_s;
    end
  end

  assign Q       = q_r;
  assign Qbar    = ~q_r;
  assign Changed = changed_r;
  assign ChgCnt  = cnt_r;

endmodule

// File: tb/tb_jk_register.sv
// Self-checking bench for jk_register. Two instances share stimulus: one with
// the default 8-bit counter and one with a 2-bit counter to exercise
// saturation. A behavioural model tracks expected state per edge.
module tb_jk_register;

  logic       Clk;
  logic       Rst_n;
  logic       En;
  logic [1:0] Mode;
  logic [7:0] J;
  logic [7:0] K;
  logic [7:0] D;
  logic       Clr;

  logic [7:0] q_a, qbar_a, chg_a, cnt_a;
  logic [7:0] q_b, qbar_b, chg_b;
  logic [1:0] cnt_b;

  int n_vec;
  int n_err;

  // Behavioural model state
  int m_q;
  int m_chg;
  int m_cnt8;
  int m_cnt2;

  jk_register #(.WIDTH(8), .CNT_W(8)) dut_a (
    .Clk(Clk), .Rst_n(Rst_n), .En(En), .Mode(Mode), .J(J), .K(K), .D(D),
    .Clr(Clr), .Q(q_a), .Qbar(qbar_a), .Changed(chg_a), .ChgCnt(cnt_a)
  );

  jk_register #(.WIDTH(8), .CNT_W(2)) dut_b (
    .Clk(Clk), .Rst_n(Rst_n), .En(En), .Mode(Mode), .J(J), .K(K), .D(D),
    .Clr(Clr), .Q(q_b), .Qbar(qbar_b), .Changed(chg_b), .ChgCnt(cnt_b)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Advance the model by one edge using the current inputs.
  task automatic model_step();
    int nq;
    int qb, jb, kb;
    if (!Rst_n) begin
      m_q = 0; m_chg = 0; m_cnt8 = 0; m_cnt2 = 0;
      return;
    end
    nq = m_q;
    if (En) begin
      if (Mode == 2'd0) begin
        nq = 0;
        for (int i = 0; i < 8; i++) begin
          qb = (m_q >> i) & 1;
          jb = J[i];
          kb = K[i];
          if (jb == 1 && kb == 1) qb = 1 - qb;
          else if (jb == 1)       qb = 1;
          else if (kb == 1)       qb = 0;
          nq = nq + qb * (1 << i);
        end
      end else if (Mode == 2'd1) begin
        nq = D;
      end else if (Mode == 2'd2) begin
        nq = m_q ^ int'(J);
      end else begin
        nq = ((m_q * 2) % 256) + (m_q / 128);
      end
    end
    m_chg = nq ^ m_q;
    m_q   = nq;
    if (Clr) begin
      m_cnt8 = 0;
      m_cnt2 = 0;
    end else if (m_chg != 0) begin
      if (m_cnt8 < 255) m_cnt8++;
      if (m_cnt2 < 3)   m_cnt2++;
    end
  endtask

  // Drive one set of inputs, clock once, then compare both instances to the model.
  task automatic apply(input logic rst_n, input logic en, input logic [1:0] mode,
                       input logic [7:0] j, input logic [7:0] k, input logic [7:0] d,
                       input logic clr);
    Rst_n = rst_n; En = en; Mode = mode; J = j; K = k; D = d; Clr = clr;
    @(posedge Clk);
    model_step();
    #1;
    chk("q_a",       32'(q_a),    32'(m_q));
    chk("qbar_a",    32'(qbar_a), 32'((~m_q) & 255));
    chk("changed_a", 32'(chg_a),  32'(m_chg));
    chk("chgcnt_a",  32'(cnt_a),  32'(m_cnt8));
    chk("q_b",       32'(q_b),    32'(m_q));
    chk("changed_b", 32'(chg_b),  32'(m_chg));
    chk("chgcnt_b",  32'(cnt_b),  32'(m_cnt2));
  endtask

  initial begin
    logic [7:0] q_hold;
    n_vec = 0; n_err = 0;
    m_q = 0; m_chg = 0; m_cnt8 = 0; m_cnt2 = 0;
    Rst_n = 1'b0; En = 1'b0; Mode = 2'b00; J = 8'h00; K = 8'h00; D = 8'h00; Clr = 1'b0;
    @(negedge Clk);

    // Reset state
    apply(1'b0, 1'b1, 2'b01, 8'hFF, 8'hFF, 8'hFF, 1'b0);
    chk("rst_q", 32'(q_a), 32'h00);
    chk("rst_qbar", 32'(qbar_a), 32'hFF);

    // JK set/clear
    apply(1'b1, 1'b1, 2'b00, 8'hF0, 8'h0F, 8'h00, 1'b0);
    chk("jk_q", 32'(q_a), 32'hF0);
    chk("jk_qbar", 32'(qbar_a), 32'h0F);
    chk("jk_chg", 32'(chg_a), 32'hF0);
    chk("jk_cnt", 32'(cnt_a), 32'd1);

    // JK invert twice
    apply(1'b1, 1'b1, 2'b00, 8'hFF, 8'hFF, 8'h00, 1'b0);
    chk("inv1_q", 32'(q_a), 32'h0F);
    chk("inv1_chg", 32'(chg_a), 32'hFF);
    apply(1'b1, 1'b1, 2'b00, 8'hFF, 8'hFF, 8'h00, 1'b0);
    chk("inv2_q", 32'(q_a), 32'hF0);
    chk("inv2_cnt", 32'(cnt_a), 32'd3);

    // Load, rotate, toggle, then disabled
    apply(1'b1, 1'b1, 2'b01, 8'h55, 8'hAA, 8'h81, 1'b0);
    chk("load_q", 32'(q_a), 32'h81);
    apply(1'b1, 1'b1, 2'b11, 8'hFF, 8'hFF, 8'hFF, 1'b0);
    chk("rot_q", 32'(q_a), 32'h03);
    apply(1'b1, 1'b1, 2'b10, 8'h01, 8'hFF, 8'h00, 1'b0);
    chk("tog_q", 32'(q_a), 32'h02);
    for (int i = 0; i < 4; i++) begin
      apply(1'b1, 1'b0, 2'(i), 8'(($urandom)), 8'($urandom), 8'($urandom), 1'b0);
      chk("en0_q", 32'(q_a), 32'h02);
      chk("en0_chg", 32'(chg_a), 32'h00);
      chk("en0_cnt", 32'(cnt_a), 32'd6);
    end

    // JK hold
    for (int i = 0; i < 3; i++) begin
      apply(1'b1, 1'b1, 2'b00, 8'h00, 8'h00, 8'($urandom), 1'b0);
      chk("hold_q", 32'(q_a), 32'h02);
      chk("hold_chg", 32'(chg_a), 32'h00);
      chk("hold_cnt", 32'(cnt_a), 32'd6);
    end

    // Saturation of the 2-bit counter, then Clr with a changing edge
    apply(1'b0, 1'b0, 2'b00, 8'h00, 8'h00, 8'h00, 1'b0);
    apply(1'b1, 1'b1, 2'b10, 8'hFF, 8'h00, 8'h00, 1'b0);
    chk("sat1", 32'(cnt_b), 32'd1);
    apply(1'b1, 1'b1, 2'b10, 8'hFF, 8'h00, 8'h00, 1'b0);
    chk("sat2", 32'(cnt_b), 32'd2);
    apply(1'b1, 1'b1, 2'b10, 8'hFF, 8'h00, 8'h00, 1'b0);
    chk("sat3", 32'(cnt_b), 32'd3);
    apply(1'b1, 1'b1, 2'b10, 8'hFF, 8'h00, 8'h00, 1'b0);
    chk("sat4", 32'(cnt_b), 32'd3);
    apply(1'b1, 1'b1, 2'b10, 8'hFF, 8'h00, 8'h00, 1'b1);
    chk("clr_cnt", 32'(cnt_b), 32'd0);
    chk("clr_q", 32'(q_b), 32'hFF);
    chk("clr_chg", 32'(chg_b), 32'hFF);

    // Reset mid-sequence overriding a load
    apply(1'b1, 1'b1, 2'b10, 8'hFF, 8'h00, 8'h00, 1'b0);
    apply(1'b1, 1'b1, 2'b10, 8'hFF, 8'h00, 8'h00, 1'b0);
    apply(1'b1, 1'b1, 2'b10, 8'hFF, 8'h00, 8'h00, 1'b0);
    apply(1'b1, 1'b1, 2'b10, 8'hFF, 8'h00, 8'h00, 1'b0);
    apply(1'b1, 1'b1, 2'b01, 8'h00, 8'h00, 8'hAA, 1'b0);
    chk("pre_q", 32'(q_a), 32'hAA);
    chk("pre_cnt", 32'(cnt_a), 32'd5);
    apply(1'b0, 1'b1, 2'b01, 8'h00, 8'h00, 8'hFF, 1'b0);
    chk("mrst_q", 32'(q_a), 32'h00);
    chk("mrst_chg", 32'(chg_a), 32'h00);
    chk("mrst_cnt", 32'(cnt_a), 32'd0);
    apply(1'b1, 1'b1, 2'b01, 8'h00, 8'h00, 8'hFF, 1'b0);
    chk("rel_q", 32'(q_a), 32'hFF);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      q_hold = 8'($urandom);
      apply(($urandom_range(31, 0) != 0),
            ($urandom_range(3, 0) != 0),
            2'($urandom_range(3, 0)),
            8'($urandom), 8'($urandom), q_hold,
            ($urandom_range(7, 0) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
